// File: rtl/reg_bank_pkg.sv
// Shared CPU constants for the register bank and its select logic.
// Holds default sizes, the error-counter ceiling and an index-width helper.
package reg_bank_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_NUM_REGS = 16;

    localparam logic [7:0] ERR_SAT = 8'd255;

    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/onehot_check.sv
// Classifies a select vector as zero, exactly one (with its index) or multiple.
// The index is only meaningful when exactly one bit is set.
module onehot_check
    import reg_bank_pkg::*;
#(
    parameter  int N  = DEF_NUM_REGS,
    localparam int IW = idx_bits(N)
) (
    input  logic [N-1:0]  vec,
    output logic          zero,
    output logic          one,
    output logic          multi,
    output logic [IW-1:0] idx
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = IW'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves nothing only for a power of two
    assign zero  = (vec == '0);
    assign one   = !zero && ((vec & (vec - N'(1))) == '0);
    assign multi = !zero && !one;

endmodule

// File: rtl/reg_bank.sv
// Bus-attached register file with one-hot read/write selects,
// base-address zero override on R0 and select-violation tracking.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic                clock,
    input  logic                clear,
    input  logic [WIDTH-1:0]    bus_in,
    input  logic [NUM_REGS-1:0] r_in,
    input  logic [NUM_REGS-1:0] r_out,
    input  logic                ba_out,
    output logic [WIDTH-1:0]    bus_out,
    output logic                bus_out_valid,
    output logic                sel_error,
    output logic [7:0]          error_count,
    input  logic [3:0]          dbg_sel,
    output logic [WIDTH-1:0]    dbg_data
);

    localparam int IW = idx_bits(NUM_REGS);

    logic [WIDTH-1:0] regs [NUM_REGS];

    logic          wr_zero, wr_one, wr_multi;
    logic          rd_zero, rd_one, rd_multi;
    logic [IW-1:0] wr_idx, rd_idx;
    logic          viol;
    logic          unused_zero;

    onehot_check #(.N(NUM_REGS)) u_wr_check (
        .vec   (r_in),
        .zero  (wr_zero),
        .one   (wr_one),
        .multi (wr_multi),
        .idx   (wr_idx)
    );

    onehot_check #(.N(NUM_REGS)) u_rd_check (
        .vec   (r_out),
        .zero  (rd_zero),
        .one   (rd_one),
        .multi (rd_multi),
        .idx   (rd_idx)
    );

    assign unused_zero = wr_zero | rd_zero;

    // A cycle with both selects bad still counts once
    assign viol = wr_multi | rd_multi;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_one) begin
            regs[wr_idx] <= bus_in;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            sel_error   <= 1'b0;
            error_count <= '0;
        end else if (viol) begin
            sel_error <= 1'b1;
            if (error_count != ERR_SAT) begin
                error_count <= error_count + 8'd1;
            end
        end
    end

    always_comb begin
        bus_out       = '0;
        bus_out_valid = rd_one;
        if (!clear && rd_one && !(ba_out && rd_idx == '0)) begin
            bus_out = regs[rd_idx];
        end
    end

    always_comb begin
        dbg_data = '0;
        if (!clear && int'(dbg_sel) < NUM_REGS) begin
            dbg_data = regs[dbg_sel];
        end
    end

endmodule

// File: doc/reg_bank.md
REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the data width of each register and of both bus ports.
REQ-002 SHALL have parameter NUM_REGS, default 16, meaning the register count and the width of the one-hot select vectors.
REQ-003 SHALL have port clock  input  1  system clock; all state updates on the rising edge.
REQ-004 SHALL have port clear  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port bus_in  input  WIDTH  write data from the bus.
REQ-006 SHALL have port r_in  input  NUM_REGS  one-hot write enables; bit i selects Ri.
REQ-007 SHALL have port r_out  input  NUM_REGS  one-hot read enables; bit i selects Ri.
REQ-008 SHALL have port ba_out  input  1  base-address read qualifier; when selected, R0 reads as zero.
REQ-009 SHALL have port bus_out  output  WIDTH  read data to the bus.
REQ-010 SHALL have port bus_out_valid  output  1  high when bus_out carries a legally selected register.
REQ-011 SHALL have port sel_error  output  1  sticky flag for a select-vector violation.
REQ-012 SHALL have port error_count  output  8  saturating count of cycles with a violation.
REQ-013 SHALL have port dbg_sel  input  4  debug register index.
REQ-014 SHALL have port dbg_data  output  WIDTH  contents of R[dbg_sel], combinational.

Function
REQ-015 SHALL write bus_in into Ri on a rising clock edge when r_in has exactly bit i set; R0 is writable.
REQ-016 SHALL perform no write when r_in is zero, and no write of any register when r_in has more than one bit set.
REQ-017 SHALL make a write visible on bus_out and dbg_data from the cycle after the write edge; reads in the write cycle return the old value.
REQ-018 SHALL drive bus_out combinationally: with exactly r_out bit i set, bus_out = Ri and bus_out_valid = 1.
REQ-019 SHALL drive bus_out = 0 and bus_out_valid = 1 when r_out = bit 0 only and ba_out = 1.
REQ-020 SHALL drive bus_out = 0 and bus_out_valid = 0 when r_out is zero or has more than one bit set.
REQ-021 SHALL treat a cycle as a violation when r_in or r_out has more than one bit set; all-zero is not a violation.
REQ-022 SHALL set sel_error on the edge ending a violation cycle and hold it until clear.
REQ-023 SHALL increment error_count by exactly 1 per violation cycle, even when r_in and r_out both violate, saturating at 255.
REQ-024 SHALL allow simultaneous legal read and write of the same register: read returns old data, write commits at the edge.

Reset
REQ-025 SHALL, while clear is high and independent of clock, force all registers to 0, sel_error to 0 and error_count to 0.
REQ-026 SHALL, during clear, present bus_out = 0 and dbg_data = 0, and ignore any write in progress.
REQ-027 SHALL resume normal writes on the first rising edge after clear deasserts.

Structure
REQ-028 SHALL take WIDTH/NUM_REGS defaults and the error_count saturation constant (255) from the shared CPU package used by the select/encode logic.
REQ-029 SHALL be built from one sub-module, onehot_check, which reports "zero", "exactly one (with index)" and "multiple" for an NUM_REGS-bit vector.
REQ-030 SHALL instantiate onehot_check once for r_in and once for r_out.

Verification
REQ-031 SHALL cover: clear, r_in=0x0008, bus_in=0x1234_5678, one edge, then r_out=0x0008 -> bus_out=0x1234_5678, bus_out_valid=1.
REQ-032 SHALL cover: R0=0xDEAD_BEEF, r_out=0x0001, ba_out=1 -> bus_out=0, valid=1; ba_out=0 -> bus_out=0xDEAD_BEEF.
REQ-033 SHALL cover: r_in=0x0006 for one edge -> R1 and R2 unchanged, sel_error=1, error_count=1.
REQ-034 SHALL cover: r_in=0x0003 and r_out=0x0030 in the same cycle -> error_count increments by 1, bus_out=0, valid=0.
REQ-035 SHALL cover: 300 consecutive violation cycles -> error_count=255, sel_error=1.
REQ-036 SHALL cover: clear asserted mid-cycle with r_in=0x8000 active -> R15=0 immediately, and error_count=0 and sel_error=0 immediately.
